display_write_arbiter: RTL
==========================

// Module: display_write_arbiter
// PURPOSE
//  Schedules writes into the 16-bit display value register that feeds the 8-digit 7-seg scanner.
//  Two requesters share the single write port:
//   - auto: the LFSR, paced by an internal MAX_COUNT tick and enabled by SW[0].
//   - manual: button/switch path, req/gnt handshake.
//  Round-robin arbitration on ties; emits the LFSR advance pulse and an overrun flag.
// PARAMETERS
//  MAX_COUNT  100_000_000  tick period in clk_100 cycles (>=2); benches use 20
//  DATA_W     16           write data width
// PORTS
//  clk_100    in   1       system clock, 100 MHz, all logic on rising edge
//  reset      in   1       synchronous, active-low; 0 = reset
//  en_auto    in   1       enable auto (LFSR) pacing; typically SW[0]
//  lfsr_data  in   DATA_W  current LFSR value
//  man_req    in   1       manual write request, level; hold until man_gnt
//  man_data   in   DATA_W  manual write value, stable while man_req=1
//  man_gnt    out  1       1-cycle grant, same cycle as the manual write
//  lfsr_step  out  1       1-cycle pulse, same cycle as the auto write; LFSR advances
//  wr_en      out  1       1-cycle write strobe to display register
//  wr_data    out  DATA_W  value written; valid when wr_en=1
//  tick       out  1       1-cycle pace pulse
//  overrun    out  1       sticky: tick arrived while auto write still pending
// BEHAVIOUR
//  Reset (reset=0 at posedge): all outputs 0; cnt=0; pend=0; state=IDLE; last=MAN.
//   - Reset overrides any state, including mid-WRITE.
//   - Outputs are registered.
//  Tick counter:
//   - en_auto=0: cnt<=0, no tick, pend<=0 (a write already in WRITE completes).
//   - en_auto=1: cnt increments. At cnt==MAX_COUNT-1: cnt<=0, tick<=1 for the next cycle, pend<=1.
//   - Period is exactly MAX_COUNT cycles.
//   - Tick while pend=1 and not cleared on the same edge: overrun<=1 (sticky until reset).
//     pend stays 1, so only one auto write is queued.
//  FSM states IDLE -> WRITE -> COOL -> IDLE:
//   - IDLE: candidates are pend (auto) and man_req (manual).
//     - Both present: grant the one != last.
//     - One present: grant it.
//     - None: stay in IDLE.
//   - Grant -> WRITE on next edge; wr_data latched from lfsr_data or man_data on that edge.
//   - WRITE (1 cycle): wr_en=1.
//     - auto: lfsr_step=1, pend<=0, last<=AUTO.
//     - manual: man_gnt=1, last<=MAN.
//   - COOL (1 cycle): all strobes 0; man_req still high here is ignored.
//   - COOL -> IDLE. Any man_req=1 seen in IDLE is a new request.
//  Timing:
//   - Max write rate: 1 per 2 cycles.
//   - Latency from a request seen in IDLE at edge k: wr_en high in the cycle after edge k.
//   - Auto write follows its tick by >=1 cycle.
//  Simultaneous events:
//   - Tick on the same edge as WRITE(auto) clears pend: pend ends 1, no overrun.
//   - Round-robin guarantees neither requester waits longer than one other write.
//  wr_data holds its last value outside WRITE.
// TESTING
//  1. reset=0 for 5 cycles, en_auto=0, 100 cycles -> wr_en/tick/man_gnt/lfsr_step/overrun stay 0.
//  2. MAX_COUNT=20, en_auto=1 for 200 cycles -> 10 ticks spaced 20 cycles apart.
//     Each tick is followed 1 cycle later by wr_en=lfsr_step=1 with wr_data=lfsr_data.
//  3. en_auto=0, man_req=1, man_data=16'hBEEF -> next cycle man_gnt=wr_en=1, wr_data=16'hBEEF.
//     Then 1 cooldown cycle with strobes 0.
//  4. pend=1 and man_req on the same edge, after reset (last=MAN) -> auto write first, manual write 2 cycles later.
//     Next tie -> manual first.
//  5. MAX_COUNT=2, en_auto=1, man_req held 1 -> writes alternate manual/auto.
//     overrun becomes 1 and stays 1.
//  6. reset=0 during WRITE -> next cycle all outputs 0, pend=0, FSM IDLE.
//     Resume with en_auto=1 -> first tick after MAX_COUNT cycles.

Source files
------------

// File: rtl/display_write_arbiter.sv
// Write scheduler for the 16-bit display value register.
// Two requesters share one write port:
//   - auto: LFSR writes paced by an internal tick counter.
//   - manual: req/gnt handshake.
// Ties are broken round-robin. Every write is followed by one cooldown cycle.
// All outputs are registered.
module display_write_arbiter #(
    parameter int MAX_COUNT = 100_000_000,
    parameter int DATA_W    = 16
) (
    input  logic              clk_100,
    input  logic              reset,
    input  logic              en_auto,
    input  logic [DATA_W-1:0] lfsr_data,
    input  logic              man_req,
    input  logic [DATA_W-1:0] man_data,
    output logic              man_gnt,
    output logic              lfsr_step,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              tick,
    output logic              overrun
);

    // state | meaning
    // IDLE  | choose between pending auto write and manual request
    // WRITE | write strobe cycle (wr_en high with man_gnt or lfsr_step)
    // COOL  | one dead cycle; a manual request still held here is ignored
    typedef enum logic [1:0] {IDLE, WRITE, COOL} state_t;
    typedef enum logic {SRC_MAN = 1'b0, SRC_AUTO = 1'b1} src_t;

    localparam int CNT_W = (MAX_COUNT > 2) ? $clog2(MAX_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_COUNT - 1);

    state_t            state_q, state_d;
    src_t              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              tick_q, tick_d;
    logic              overrun_q, overrun_d;
    logic              wr_en_q, wr_en_d;
    logic              man_gnt_q, man_gnt_d;
    logic              lfsr_step_q, lfsr_step_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              tick_evt;
    logic              grant_auto;
    logic              grant_man;

    // Pace counter and the single-entry auto-write queue. A tick that lands on
    // the same edge as an auto grant re-arms pend without flagging overrun.
    always_comb begin
        tick_evt  = en_auto && (cnt_q == CNT_LAST);
        cnt_d     = '0;
        tick_d    = tick_evt;
        pend_d    = pend_q;
        overrun_d = overrun_q | (tick_evt & pend_q & ~grant_auto);
        if (en_auto && !tick_evt) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (!en_auto) begin
            pend_d = 1'b0;
        end else if (tick_evt) begin
            pend_d = 1'b1;
        end else if (grant_auto) begin
            pend_d = 1'b0;
        end
    end

    // Arbitration and next-state; the write strobes are computed one edge early
    // so they appear registered during the WRITE cycle.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        man_gnt_d   = 1'b0;
        lfsr_step_d = 1'b0;
        grant_auto  = 1'b0;
        grant_man   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q && man_req) begin
                    if (last_q == SRC_AUTO) grant_man = 1'b1;
                    else                    grant_auto = 1'b1;
                end else if (pend_q) begin
                    grant_auto = 1'b1;
                end else if (man_req) begin
                    grant_man = 1'b1;
                end
                if (grant_auto) begin
                    state_d     = WRITE;
                    wr_en_d     = 1'b1;
                    lfsr_step_d = 1'b1;
                    wr_data_d   = lfsr_data;
                    last_d      = SRC_AUTO;
                end else if (grant_man) begin
                    state_d   = WRITE;
                    wr_en_d   = 1'b1;
                    man_gnt_d = 1'b1;
                    wr_data_d = man_data;
                    last_d    = SRC_MAN;
                end
            end
            WRITE:   state_d = COOL;
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_100) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_q      <= SRC_MAN;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            tick_q      <= 1'b0;
            overrun_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            man_gnt_q   <= 1'b0;
            lfsr_step_q <= 1'b0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            tick_q      <= tick_d;
            overrun_q   <= overrun_d;
            wr_en_q     <= wr_en_d;
            man_gnt_q   <= man_gnt_d;
            lfsr_step_q <= lfsr_step_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign man_gnt   = man_gnt_q;
    assign lfsr_step = lfsr_step_q;
    assign wr_en     = wr_en_q;
    assign wr_data   = wr_data_q;
    assign tick      = tick_q;
    assign overrun   = overrun_q;

endmodule
